// File: rtl/write_pkg.sv
// Shared types for the write-back stage: register file shape, flag layout
// and the store-port state encoding.
package write_pkg;

    localparam int NR = 32;
    localparam int RW = $clog2(NR);

    typedef logic [NR-1:0][31:0] regfile_t;

    // Bit order matches the 4-bit flags bus: {N,Z,C,V}
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic {
        IDLE,
        STORE
    } write_state_t;

endpackage

// File: rtl/i_execute_to_write.sv
// Execute -> write hand-off. Execute drives the instruction fields, write
// answers with hold while a store is still on the bus.
interface i_execute_to_write;
    import write_pkg::*;

    logic [31:0]   pc;
    logic [31:0]   adjustment;
    logic [31:0]   destination_value;
    logic [RW-1:0] destination;
    logic [3:0]    flags;
    logic          destination_is_memory;
    logic          has_flushed;
    logic          is_valid;
    logic          hold;

    modport write_in (
        input  pc, adjustment, destination_value, destination, flags,
               destination_is_memory, has_flushed, is_valid,
        output hold
    );

    modport execute_out (
        output pc, adjustment, destination_value, destination, flags,
               destination_is_memory, has_flushed, is_valid,
        input  hold
    );

endinterface

// File: rtl/write_store_port.sv
// Store bus master: latches one store, holds it until the bus drops
// waitrequest, and gives up with a sticky bus_error after WATCHDOG cycles.
module write_store_port
    import write_pkg::*;
#(
    parameter int WATCHDOG = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        data_waitrequest,
    output logic        busy,
    output logic [31:0] data_address,
    output logic [31:0] data_write_data,
    output logic        data_write_enable,
    output logic        bus_error
);

    // Last count value before expiry, so STORE lasts at most WATCHDOG cycles.
    localparam logic [7:0] WD_LAST = 8'(WATCHDOG - 1);

    write_state_t state, state_next;
    logic [7:0]   wait_cnt;
    logic         expire;

    always_comb begin
        state_next = state;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = STORE;
            end
            STORE: begin
                if (!data_waitrequest) begin
                    state_next = IDLE;
                end else if (wait_cnt == WD_LAST) begin
                    state_next = IDLE;
                    expire     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            data_address    <= '0;
            data_write_data <= '0;
            bus_error       <= 1'b0;
        end else begin
            state     <= state_next;
            bus_error <= bus_error | expire;
            if (state == IDLE && start) begin
                data_address    <= address;
                data_write_data <= write_data;
                wait_cnt        <= '0;
            end else if (state == STORE && data_waitrequest) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign busy              = (state == STORE);
    assign data_write_enable = busy;

endmodule

// File: rtl/write.sv
// Final pipeline stage: commits register results, issues stores through the
// store port, tracks the flush epoch and pulses a PC redirect.
module write
    import write_pkg::*;
#(
    parameter int WATCHDOG = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    i_execute_to_write.write_in ini,
    output regfile_t           registers,
    output flags_t             flags,
    output logic [31:0]        data_address,
    output logic [31:0]        data_write_data,
    output logic               data_write_enable,
    input  logic               data_waitrequest,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic               bus_error
);

    logic        busy;
    logic        epoch;
    logic        take, take_reg, take_store;
    logic [31:0] store_address;
    logic        unused_pc;

    // Sequential PC belongs to fetch; pc is carried on the bus but not consumed.
    assign unused_pc = ^ini.pc;

    assign ini.hold   = busy;
    assign take       = ini.is_valid && !busy && (ini.has_flushed == epoch);
    assign take_reg   = take && !ini.destination_is_memory;
    assign take_store = take && ini.destination_is_memory;

    assign store_address = registers[ini.destination] + ini.adjustment;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            registers   <= '0;
            flags       <= '0;
            epoch       <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= 1'b0;
            if (take) flags <= flags_t'(ini.flags);
            if (take_reg && ini.destination != '0)
                registers[ini.destination] <= ini.destination_value;
            // Writing the PC starts a new epoch so in-flight younger work is dropped.
            if (take_reg && ini.destination == RW'(NR - 1)) begin
                epoch       <= ~epoch;
                redirect    <= 1'b1;
                redirect_pc <= ini.destination_value;
            end
        end
    end

    write_store_port #(
        .WATCHDOG(WATCHDOG)
    ) u_store (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (take_store),
        .address           (store_address),
        .write_data        (ini.destination_value),
        .data_waitrequest  (data_waitrequest),
        .busy              (busy),
        .data_address      (data_address),
        .data_write_data   (data_write_data),
        .data_write_enable (data_write_enable),
        .bus_error         (bus_error)
    );

endmodule
